rc4_key_worker: RTL



---
 rtl/rc4_key_worker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_key_worker.sv
// Single-key RC4 decryption worker: rebuilds the S-box, runs KSA with the latched
// key, decrypts the message ROM into the plaintext RAM and flags success/failure.
module rc4_key_worker #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_all,
    input  logic [23:0]       secret_key,
    output logic              success,
    output logic              failure,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [MSG_AW-1:0] d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren
);

    localparam logic [4:0] ST_IDLE   = 5'd0;
    localparam logic [4:0] ST_INIT   = 5'd1;
    localparam logic [4:0] KSA_RD_I  = 5'd2;
    localparam logic [4:0] KSA_WT_I  = 5'd3;
    localparam logic [4:0] KSA_RD_J  = 5'd4;
    localparam logic [4:0] KSA_WT_J  = 5'd5;
    localparam logic [4:0] KSA_WR_I  = 5'd6;
    localparam logic [4:0] KSA_WR_J  = 5'd7;
    localparam logic [4:0] PR_INC    = 5'd8;
    localparam logic [4:0] PR_RD_I   = 5'd9;
    localparam logic [4:0] PR_WT_I   = 5'd10;
    localparam logic [4:0] PR_RD_J   = 5'd11;
    localparam logic [4:0] PR_WT_J   = 5'd12;
    localparam logic [4:0] PR_WR_I   = 5'd13;
    localparam logic [4:0] PR_WR_J   = 5'd14;
    localparam logic [4:0] PR_RD_F   = 5'd15;
    localparam logic [4:0] PR_WT_F   = 5'd16;
    localparam logic [4:0] PR_OUT    = 5'd17;
    localparam logic [4:0] ST_DONE   = 5'd18;
    localparam logic [4:0] ST_FAIL   = 5'd19;

    localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

    logic [4:0]        state, state_nxt;
    logic [7:0]        i, i_nxt, j, j_nxt, si, si_nxt, sj, sj_nxt;
    logic [1:0]        kidx, kidx_nxt;
    logic [MSG_AW-1:0] k, k_nxt;
    logic [23:0]       key, key_nxt;
    logic [7:0]        s_addr_nxt, s_wdata_nxt, d_wdata_nxt;
    logic [MSG_AW-1:0] rom_addr_nxt, d_addr_nxt;
    logic              s_wren_nxt, d_wren_nxt, success_nxt, failure_nxt;
    logic [7:0]        key_byte, ksa_j, prga_j, plain;
    logic              plain_ok;

    // Key byte for the current i mod 3 position, tracked by a wrap counter
    always_comb begin
        key_byte = key[7:0];
        case (kidx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

    assign ksa_j    = j + s_rdata + key_byte;
    assign prga_j   = j + s_rdata;
    assign plain    = s_rdata ^ rom_rdata;
    assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            i        <= 8'd0;
            j        <= 8'd0;
            si       <= 8'd0;
            sj       <= 8'd0;
            kidx     <= 2'd0;
            k        <= '0;
            key      <= 24'd0;
            s_addr   <= 8'd0;
            s_wdata  <= 8'd0;
            s_wren   <= 1'b0;
            rom_addr <= '0;
            d_addr   <= '0;
            d_wdata  <= 8'd0;
            d_wren   <= 1'b0;
            success  <= 1'b0;
            failure  <= 1'b0;
        end else begin
            state    <= state_nxt;
            i        <= i_nxt;
            j        <= j_nxt;
            si       <= si_nxt;
            sj       <= sj_nxt;
            kidx     <= kidx_nxt;
            k        <= k_nxt;
            key      <= key_nxt;
            s_addr   <= s_addr_nxt;
            s_wdata  <= s_wdata_nxt;
            s_wren   <= s_wren_nxt;
            rom_addr <= rom_addr_nxt;
            d_addr   <= d_addr_nxt;
            d_wdata  <= d_wdata_nxt;
            d_wren   <= d_wren_nxt;
            success  <= success_nxt;
            failure  <= failure_nxt;
        end
    end

    // Reads are issued one state ahead of their WT state; data is captured in the state after WT
    always_comb begin
        state_nxt    = state;
        i_nxt        = i;
        j_nxt        = j;
        si_nxt       = si;
        sj_nxt       = sj;
        kidx_nxt     = kidx;
        k_nxt        = k;
        key_nxt      = key;
        s_addr_nxt   = s_addr;
        s_wdata_nxt  = s_wdata;
        s_wren_nxt   = 1'b0;
        rom_addr_nxt = rom_addr;
        d_addr_nxt   = d_addr;
        d_wdata_nxt  = d_wdata;
        d_wren_nxt   = 1'b0;
        success_nxt  = success;
        failure_nxt  = failure;

        if (!reset_all) begin
            state_nxt   = ST_IDLE;
            success_nxt = 1'b0;
            failure_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    key_nxt   = secret_key;
                    i_nxt     = 8'd0;
                    state_nxt = ST_INIT;
                end
                ST_INIT: begin
                    s_addr_nxt  = i;
                    s_wdata_nxt = i;
                    s_wren_nxt  = 1'b1;
                    i_nxt       = i + 8'd1;
                    if (i == 8'hFF) begin
                        j_nxt     = 8'd0;
                        kidx_nxt  = 2'd0;
                        state_nxt = KSA_RD_I;
                    end
                end
                KSA_RD_I: begin
                    s_addr_nxt = i;
                    state_nxt  = KSA_WT_I;
                end
                KSA_WT_I: state_nxt = KSA_RD_J;
                KSA_RD_J: begin
                    si_nxt     = s_rdata;
                    j_nxt      = ksa_j;
                    s_addr_nxt = ksa_j;
                    state_nxt  = KSA_WT_J;
                end
                KSA_WT_J: state_nxt = KSA_WR_I;
                KSA_WR_I: begin
                    sj_nxt      = s_rdata;
                    s_addr_nxt  = i;
                    s_wdata_nxt = s_rdata;
                    s_wren_nxt  = 1'b1;
                    state_nxt   = KSA_WR_J;
                end
                KSA_WR_J: begin
                    s_addr_nxt  = j;
                    s_wdata_nxt = si;
                    s_wren_nxt  = 1'b1;
                    i_nxt       = i + 8'd1;
                    kidx_nxt    = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    if (i == 8'hFF) begin
                        j_nxt     = 8'd0;
                        k_nxt     = '0;
                        state_nxt = PR_INC;
                    end else begin
                        state_nxt = KSA_RD_I;
                    end
                end
                PR_INC: begin
                    i_nxt     = i + 8'd1;
                    state_nxt = PR_RD_I;
                end
                PR_RD_I: begin
                    s_addr_nxt = i;
                    state_nxt  = PR_WT_I;
                end
                PR_WT_I: state_nxt = PR_RD_J;
                PR_RD_J: begin
                    si_nxt     = s_rdata;
                    j_nxt      = prga_j;
                    s_addr_nxt = prga_j;
                    state_nxt  = PR_WT_J;
                end
                PR_WT_J: state_nxt = PR_WR_I;
                PR_WR_I: begin
                    sj_nxt      = s_rdata;
                    s_addr_nxt  = i;
                    s_wdata_nxt = s_rdata;
                    s_wren_nxt  = 1'b1;
                    state_nxt   = PR_WR_J;
                end
                PR_WR_J: begin
                    s_addr_nxt  = j;
                    s_wdata_nxt = si;
                    s_wren_nxt  = 1'b1;
                    state_nxt   = PR_RD_F;
                end
                PR_RD_F: begin
                    s_addr_nxt   = si + sj;
                    rom_addr_nxt = k;
                    state_nxt    = PR_WT_F;
                end
                PR_WT_F: state_nxt = PR_OUT;
                PR_OUT: begin
                    d_addr_nxt  = k;
                    d_wdata_nxt = plain;
                    d_wren_nxt  = 1'b1;
                    if (!plain_ok) begin
                        failure_nxt = 1'b1;
                        state_nxt   = ST_FAIL;
                    end else if (k == LAST_K) begin
                        success_nxt = 1'b1;
                        state_nxt   = ST_DONE;
                    end else begin
                        k_nxt     = k + MSG_AW'(1);
                        state_nxt = PR_INC;
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                ST_FAIL: state_nxt = ST_FAIL;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule
